btn_debounce_pair: RTL

- Two-channel input conditioner that sits directly upstream of the a/b-driven control FSMs.
- Takes raw, bouncing, asynchronous push-button/switch levels and synchronises each into clk.
- Debounces each channel with a per-channel 4-state FSM plus down-counter.
- Delivers clean levels (db_a, db_b) and single-cycle rising-edge ticks (tick_a, tick_b); the downstream FSM's a/b inputs connect to db_a/db_b.

---
 rtl/btn_debounce_pair.sv | 114 +++++++++++
 1 files changed

// File: rtl/btn_debounce_pair.sv
// Two-channel push-button conditioner: synchronises raw levels into clk,
// debounces each channel with a four-state FSM and a down-counter, and
// produces clean levels plus single-cycle rising-edge ticks.
//
// state | meaning
// ZERO  | debounced level is 0, input agrees
// WAIT1 | input went to 1, counting down a full stable interval
// ONE   | debounced level is 1, input agrees
// WAIT0 | input went to 0, counting down a full stable interval
module btn_debounce_pair #(
  parameter int CNT_W = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_a,
  input  logic sw_b,
  output logic db_a,
  output logic db_b,
  output logic tick_a,
  output logic tick_b
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] sw_raw;
  assign sw_raw = {sw_b, sw_a};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;
    logic             tick_q;

    // Two-flop synchroniser; only the second flop is ever looked at.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= sw_raw[ch];
        sync2_q <= sync1_q;
      end
    end

    // Debounce FSM; db/tick are registered alongside the state so they
    // change on exactly the edge the state settles into ONE or ZERO.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ZERO;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        case (state_q)
          ZERO: begin
            if (sync2_q) begin
              state_q <= WAIT1;
              cnt_q   <= CNT_MAX;
            end
          end
          WAIT1: begin
            // A returning glitch wins over an expiring counter.
            if (!sync2_q) begin
              state_q <= ZERO;
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              state_q <= ONE;
              db_q    <= 1'b1;
              tick_q  <= 1'b1;
            end
          end
          ONE: begin
            if (!sync2_q) begin
              state_q <= WAIT0;
              cnt_q   <= CNT_MAX;
            end
          end
          WAIT0: begin
            // Recovering to ONE is glitch rejection, so no tick here.
            if (sync2_q) begin
              state_q <= ONE;
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              state_q <= ZERO;
              db_q    <= 1'b0;
            end
          end
          default: begin
            state_q <= ZERO;
            db_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign db_a   = g_ch[0].db_q;
  assign db_b   = g_ch[1].db_q;
  assign tick_a = g_ch[0].tick_q;
  assign tick_b = g_ch[1].tick_q;

endmodule
